crc8_frame_engine: RTL and testbench
====================================

CRC8_FRAME_ENGINE -- requirements
Module: crc8_frame_engine

Interface
REQ-001 SHALL have parameter POLY, default 8'h07, CRC-8 generator polynomial (implicit x^8).
REQ-002 SHALL have parameter INIT, default 8'h00, CRC register value at start of each frame.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port in_data, input, 8, frame byte.
REQ-006 SHALL have port in_valid, input, 1, in_data/in_last valid.
REQ-007 SHALL have port in_last, input, 1, byte is final byte of frame.
REQ-008 SHALL have port in_ready, output, 1, engine can accept a byte.
REQ-009 SHALL have port crc_out, output, 8, final frame CRC.
REQ-010 SHALL have port crc_valid, output, 1, crc_out valid.
REQ-011 SHALL have port crc_ready, input, 1, consumer accepts crc_out.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, OUT.
REQ-014 Byte transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; in_ready SHALL be 1 only in IDLE.
REQ-015 On transfer, SHALL latch in_data and in_last, clear the 3-bit bit counter, and enter SHIFT next cycle.
REQ-016 Changes to in_data/in_last after transfer SHALL have no effect on the result.
REQ-017 In SHIFT, SHALL process one data bit per cycle, MSB first, for exactly 8 cycles.
- per bit: fb = crc[7] ^ d; crc = {crc[6:0],1'b0} ^ (fb ? POLY : 8'h00)
REQ-018 After the 8th SHIFT cycle, SHALL go to OUT if the latched last is 1, else to IDLE.
- Byte accepted at cycle T: SHIFT T+1..T+8, IDLE or OUT at T+9.
- Throughput: 1 byte per 9 cycles.
REQ-019 In OUT, crc_valid SHALL be 1 and crc_out SHALL equal the CRC register, held stable until crc_ready=1.
REQ-020 On a cycle in OUT with crc_ready=1, SHALL return to IDLE next cycle and reload CRC register with INIT.
REQ-021 crc_out SHALL be 8'h00 whenever crc_valid=0.
REQ-022 crc_ready SHALL be ignored outside OUT; in_valid SHALL be ignored outside IDLE.
REQ-023 CRC register SHALL carry across non-last bytes of the same frame; it SHALL be INIT at the first byte of every frame.
REQ-024 A frame SHALL be at least one byte; a single byte with in_last=1 is a complete frame.
REQ-025 Back-to-back frames: a new byte SHALL be accepted in the first IDLE cycle after the OUT handshake.

Reset
REQ-026 While reset=1 at a clock edge, SHALL enter IDLE, load CRC register with INIT, and clear the bit counter and latched data/last.
REQ-027 After reset: in_ready=1, crc_valid=0, crc_out=8'h00, busy=0.
REQ-028 Reset asserted mid-SHIFT or in OUT SHALL abort the frame with no crc_valid pulse; the next frame starts from INIT.
REQ-029 Reset SHALL take priority over a simultaneous transfer or crc handshake.

Verification
REQ-030 Single byte 8'h01, in_last=1, crc_ready=1 -> crc_valid at T+9, crc_out=8'h07; IDLE at T+10.
REQ-031 Single byte 8'hFF, in_last=1 -> crc_out=8'hF3.
REQ-032 ASCII "123456789" (9 bytes, in_last on 8'h39), in_valid held high -> in_ready pulses every 9 cycles; crc_out=8'hF4.
REQ-033 crc_ready held 0 for 20 cycles in OUT -> crc_valid and crc_out stay stable, in_ready=0; handshake then returns to IDLE.
REQ-034 Reset asserted at 4th SHIFT cycle of "12" frame, then frame 8'h01 with last -> no crc_valid before reset; second frame crc_out=8'h07.
REQ-035 Two back-to-back frames 8'h01 and 8'hFF -> second result 8'hF3, unaffected by first (INIT reload).

Source files
------------

// File: rtl/crc8_frame_engine.sv
// rtl/crc8_frame_engine.sv - bit-serial CRC-8 over byte frames, one bit per cycle, MSB first.
// Bytes are accepted only in IDLE; the frame CRC is presented in OUT until crc_ready.
module crc8_frame_engine #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] crc_out,
  output logic       crc_valid,
  input  logic       crc_ready,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

  state_t     state;
  logic [7:0] crc;
  logic [7:0] data;
  logic       last;
  logic [2:0] bit_cnt;
  logic       fb;
  logic [7:0] crc_next;

  // data is shifted left each SHIFT cycle, so data[7] is always the current bit
  always_comb begin
    fb       = crc[7] ^ data[7];
    crc_next = {crc[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      crc       <= INIT;
      data      <= 8'h00;
      last      <= 1'b0;
      bit_cnt   <= 3'd0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      crc_valid <= 1'b0;
      crc_out   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data     <= in_data;
            last     <= in_last;
            bit_cnt  <= 3'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          crc     <= crc_next;
          data    <= {data[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (last) begin
              crc_valid <= 1'b1;
              crc_out   <= crc_next;
              state     <= OUT;
            end else begin
              in_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        OUT: begin
          if (crc_ready) begin
            crc       <= INIT;
            crc_valid <= 1'b0;
            crc_out   <= 8'h00;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          crc       <= INIT;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          crc_valid <= 1'b0;
          crc_out   <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc8_frame_engine.sv
// tb/tb_crc8_frame_engine.sv - scoreboard bench for crc8_frame_engine.
module tb_crc8_frame_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] crc_out;
  logic       crc_valid;
  logic       crc_ready = 1'b1;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_t = 0;
  int prev_xfer = -1;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  crc8_frame_engine #(.POLY(8'h07), .INIT(8'h00)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .crc_out(crc_out),
    .crc_valid(crc_valid), .crc_ready(crc_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference CRC-8, bit-serial MSB first
  function automatic logic [7:0] crc_model(input logic [7:0] bytes[$]);
    logic [7:0] c = 8'h00;
    foreach (bytes[i])
      for (int b = 7; b >= 0; b--)
        c = (c[7] ^ bytes[i][b]) ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (crc_valid && !prev_valid) begin
        if (exp_q.size() == 0) check("spurious_valid", crc_valid, 1'b0);
        else check("latency", cyc - last_t, 9);
      end
      if (crc_valid && crc_ready && exp_q.size() > 0) check("crc", crc_out, exp_q.pop_front());
      if (!crc_valid) check("crc_out_zero", crc_out, 8'h00);
      check("busy_vs_ready", busy, !in_ready);
    end
    prev_valid = crc_valid;
  end

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input logic last, input logic [7:0] exp, input int gap);
    int n = 0;
    in_data = b; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", in_ready, 1'b1);
    if (gap > 0 && prev_xfer >= 0) check("accept_gap", cyc - prev_xfer, gap);
    prev_xfer = cyc;
    if (last) begin
      exp_q.push_back(exp);
      last_t = cyc;
    end
    @(posedge clk);
    #1;
    in_data = 8'($urandom);
    in_last = 1'($urandom);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input logic [7:0] exp, input int first_gap, input int gap);
    foreach (bytes[i])
      send_byte(bytes[i], i == bytes.size() - 1, exp, (i == 0) ? first_gap : gap);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] fr[$];
    logic [7:0] hold;
    int n;

    // reset held with a pending byte: reset wins
    in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_crc_valid", crc_valid, 1'b0);
    check("rst_crc_out", crc_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_idle", busy, 1'b0);

    fr = '{8'h01};
    send_frame(fr, 8'h07, 0, 0);
    repeat (12) @(negedge clk);
    check("idle_after_01", in_ready, 1'b1);

    fr = '{8'hFF};
    send_frame(fr, 8'hF3, 0, 0);
    repeat (12) @(negedge clk);

    fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frame(fr, 8'hF4, 0, 9);
    repeat (12) @(negedge clk);

    // consumer stall for 20 cycles
    crc_ready = 1'b0;
    fr = '{8'h31, 8'h32};
    hold = crc_model(fr);
    send_frame(fr, hold, 0, 9);
    n = 0;
    while (!crc_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_valid_seen", crc_valid, 1'b1);
    for (int i = 0; i < 20; i++) begin
      check("stall_valid", crc_valid, 1'b1);
      check("stall_crc", crc_out, hold);
      check("stall_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    crc_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_hs_ready", in_ready, 1'b1);
    check("post_hs_valid", crc_valid, 1'b0);

    // reset in the 4th SHIFT cycle of a "12" frame aborts it
    send_byte(8'h31, 1'b0, 8'h00, 0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_crc_valid", crc_valid, 1'b0);
    fr = '{8'h01};
    send_frame(fr, 8'h07, 0, 0);
    repeat (12) @(negedge clk);

    // back-to-back frames: second accepted at the first IDLE cycle
    fr = '{8'h01};
    send_frame(fr, 8'h07, 0, 0);
    fr = '{8'hFF};
    send_frame(fr, 8'hF3, 10, 0);
    repeat (12) @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      fr = {};
      for (int j = 0; j <= int'($urandom_range(3)); j++) fr.push_back(8'($urandom));
      send_frame(fr, crc_model(fr), 0, 9);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
